mmio_periph_arbiter: RTL and testbench
======================================

# mmio_periph_arbiter

Round-robin arbiter with bus locking. It shares the single register port of the custom peripheral block (bin2bcd and timer registers) between two requesters: the core load/store unit and the debug/DMA master. It sits between those masters and the peripheral's `addr_i`/`write_en_i`/`data_i`/`data_o` port and performs at most one access per cycle. A requester may lock the port so that a read-modify-write sequence (for example, timer_start followed by timer_enable) is not interleaved with the other requester's accesses.

## Interface
- `N_REQ`, 2, number of requesters; only 2 is supported.
- `ADDR_W`, 8, peripheral address width.
- `DATA_W`, 32, data width.
- `LOCK_MAX`, 16, maximum number of cycles a lock may be held before forced release; must be ≥ 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid_i`  in  N_REQ  request valid, one bit per requester.
- `req_ready_o`  out  N_REQ  grant/accept, one bit per requester; combinational.
- `req_addr_i`  in  N_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- `req_we_i`  in  N_REQ  1 = write, 0 = read.
- `req_wdata_i`  in  N_REQ*DATA_W  packed write data.
- `req_lock_i`  in  N_REQ  request to acquire or keep the lock after this access.
- `rsp_valid_o`  out  N_REQ  one-cycle response pulse to the requester that was served.
- `rsp_rdata_o`  out  DATA_W  registered read data; shared by both requesters, qualified by `rsp_valid_o`.
- `per_addr_o`  out  ADDR_W  address to the peripheral.
- `per_write_en_o`  out  1  write enable to the peripheral.
- `per_data_o`  out  DATA_W  write data to the peripheral.
- `per_data_i`  in  DATA_W  combinational read data from the peripheral.
- `lock_timeout_o`  out  1  one-cycle pulse when a lock is force-released.

## Operation
**States**
- IDLE: no lock is held.
- LOCKED: an owner is recorded, and only the owner can be granted.

**Winner selection**
- In IDLE, when exactly one request is valid, that requester wins.
- In IDLE, when both requests are valid, the requester that is not `last_gnt` wins.
- In LOCKED, the winner is the owner if the owner's `req_valid_i` is set; otherwise there is no winner.

**Grant and peripheral drive**
- `req_ready_o[w]` = 1 only for the winner w.
- The peripheral outputs are driven from the winner:
  - `per_addr_o` = winner address.
  - `per_data_o` = winner write data.
  - `per_write_en_o` = winner `req_we_i`.
- With no winner, all `per_*` outputs are 0.
- A transfer occurs when valid & ready at a rising edge.

**At each transfer**
- `last_gnt` ← w.
- `rsp_valid_o[w]` pulses on the next cycle, for both reads and writes.
- `rsp_rdata_o` ← `per_data_i` for reads; it holds its previous value for writes.

**Lock transitions**
- IDLE → LOCKED on a transfer with `req_lock_i[w]` = 1. On entry: owner ← w, lock counter ← 0.
- LOCKED → IDLE on an owner transfer with `req_lock_i` = 0. This is a normal release; no timeout pulse.
- The lock counter increments every cycle spent in LOCKED, including cycles with no transfer.
- If the counter equals `LOCK_MAX-1` at an edge and no normal release occurs at that edge:
  - go to IDLE;
  - `lock_timeout_o` = 1 on the next cycle.
- An owner transfer at the timeout edge completes normally; its lock bit is ignored.
- An owner transfer with `req_lock_i` = 1 while already LOCKED keeps the lock and does not restart the counter.

**Other rules**
- `req_we_i` and `req_wdata_i` of a non-winning requester are ignored.
- A requester must hold valid and payload stable until ready.
- Addresses pass through unmodified; decoding is done by the peripheral.

## Timing
**Reset values**
- State IDLE, `last_gnt` = 1 (requester 0 wins the first tie), lock counter 0.
- `rsp_valid_o` = 0, `rsp_rdata_o` = 0, `lock_timeout_o` = 0.

**Latency and throughput**
- valid → ready/`per_*`: combinational, 0 cycles.
- Transfer edge → `rsp_valid_o`/`rsp_rdata_o`: 1 cycle.
- Throughput: one transfer per cycle. Back-to-back transfers to alternating requesters are allowed.

**Peripheral timing**
- Peripheral writes take effect at the transfer edge.
- The value read at address 0x04 reflects the value of register 0x00 as it stood before that edge.

**Reset asserted mid-operation**
- Any lock is dropped.
- A pending response is discarded; `rsp_valid_o` goes to 0 immediately.
- The next access restarts from the reset arbitration state.

## Test plan
- **Single read.** Requester 0 reads 0x00 after reset → `req_ready_o` = 01 in the same cycle; next cycle `rsp_valid_o` = 01 and `rsp_rdata_o` = 0.
- **Write then dependent read.** Requester 1 writes 0x00 = 1234, then reads 0x04 → `per_write_en_o` = 1 for one cycle; the read response is 0x1234, with `rsp_valid_o` = 10 each time.
- **Round-robin under contention.** Both requesters hold valid for 4 cycles → grant order 0, 1, 0, 1; each `rsp_valid_o` follows its transfer by 1 cycle.
- **Lock hold and release.** Requester 0 writes 0x10 with lock = 1 while requester 1 is valid → requester 1 sees ready = 0 until requester 0 writes 0x18 = 1 with lock = 0; requester 1 is granted on the following cycle.
- **Forced release.** Requester 0 locks and then goes idle, `LOCK_MAX` = 16 → `lock_timeout_o` pulses 16 cycles after lock entry; requester 1 is granted in the next cycle.
- **Reset mid-lock.** `reset_n` is pulsed low while requester 1 holds the lock with a response pending → all outputs return to reset values; the next tie is granted to requester 0.

Source files
------------

// File: rtl/mmio_periph_arbiter.sv
// mmio_periph_arbiter
// Shares the single register port of the custom peripheral between two
// requesters (core LSU and debug/DMA) with round-robin arbitration and an
// optional bus lock for read-modify-write sequences.
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   req_valid_i        per-requester request valid
//   req_ready_o        per-requester grant (combinational)
//   req_addr_i         packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_we_i           per-requester write enable (1 = write)
//   req_wdata_i        packed write data, requester i at [i*DATA_W +: DATA_W]
//   req_lock_i         acquire/keep the lock after this access
//   rsp_valid_o        one-cycle response pulse to the served requester
//   rsp_rdata_o        registered read data, qualified by rsp_valid_o
//   per_addr_o         peripheral address (combinational, 0 with no winner)
//   per_write_en_o     peripheral write enable (combinational)
//   per_data_o         peripheral write data (combinational)
//   per_data_i         peripheral read data (combinational from peripheral)
//   lock_timeout_o     one-cycle pulse when a lock is force-released
//
// Only N_REQ = 2 is supported. LOCK_MAX must be >= 2.
module mmio_periph_arbiter #(
    parameter int unsigned N_REQ    = 2,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        req_valid_i,
    output logic [N_REQ-1:0]        req_ready_o,
    input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [N_REQ-1:0]        req_we_i,
    input  logic [N_REQ*DATA_W-1:0] req_wdata_i,
    input  logic [N_REQ-1:0]        req_lock_i,
    output logic [N_REQ-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]       rsp_rdata_o,
    output logic [ADDR_W-1:0]       per_addr_o,
    output logic                    per_write_en_o,
    output logic [DATA_W-1:0]       per_data_o,
    input  logic [DATA_W-1:0]       per_data_i,
    output logic                    lock_timeout_o
);

    localparam int unsigned CNT_W = $clog2(LOCK_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              lock_timeout_q, lock_timeout_d;

    logic              win_vld;
    logic              win_idx;
    logic              win_we;
    logic              win_lock;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    // Winner selection: round-robin in IDLE, owner-only in LOCKED.
    always_comb begin
        win_vld = 1'b0;
        win_idx = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i[0] && req_valid_i[1]) begin
                    win_vld = 1'b1;
                    win_idx = ~last_gnt_q;
                end else if (req_valid_i[0]) begin
                    win_vld = 1'b1;
                    win_idx = 1'b0;
                end else if (req_valid_i[1]) begin
                    win_vld = 1'b1;
                    win_idx = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (req_valid_i[owner_q]) begin
                    win_vld = 1'b1;
                    win_idx = owner_q;
                end
            end
            default: begin
                win_vld = 1'b0;
                win_idx = 1'b0;
            end
        endcase
    end

    // Winner payload mux.
    always_comb begin
        win_we    = req_we_i[win_idx];
        win_lock  = req_lock_i[win_idx];
        win_addr  = win_idx ? req_addr_i[2*ADDR_W-1:ADDR_W] : req_addr_i[ADDR_W-1:0];
        win_wdata = win_idx ? req_wdata_i[2*DATA_W-1:DATA_W] : req_wdata_i[DATA_W-1:0];
    end

    // Grant and peripheral drive; everything is zero when nobody wins.
    always_comb begin
        req_ready_o    = '0;
        per_addr_o     = '0;
        per_write_en_o = 1'b0;
        per_data_o     = '0;
        if (win_vld) begin
            req_ready_o    = N_REQ'(1) << win_idx;
            per_addr_o     = win_addr;
            per_write_en_o = win_we;
            per_data_o     = win_wdata;
        end
    end

    // Next state. The winner is always ready, so win_vld marks a transfer.
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_gnt_d     = last_gnt_q;
        lock_cnt_d     = lock_cnt_q;
        rsp_valid_d    = req_ready_o;
        rsp_rdata_d    = rsp_rdata_q;
        lock_timeout_d = 1'b0;

        if (win_vld) begin
            last_gnt_d = win_idx;
            if (!win_we) begin
                rsp_rdata_d = per_data_i;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (win_vld && win_lock) begin
                    state_d    = ST_LOCKED;
                    owner_d    = win_idx;
                    lock_cnt_d = '0;
                end
            end
            ST_LOCKED: begin
                // In LOCKED the only possible winner is the owner.
                if (win_vld && !win_lock) begin
                    state_d = ST_IDLE;
                end else if (lock_cnt_q == CNT_LAST) begin
                    state_d        = ST_IDLE;
                    lock_timeout_d = 1'b1;
                end else begin
                    lock_cnt_d = lock_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register. last_gnt resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            owner_q        <= 1'b0;
            last_gnt_q     <= 1'b1;
            lock_cnt_q     <= '0;
            rsp_valid_q    <= '0;
            rsp_rdata_q    <= '0;
            lock_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            last_gnt_q     <= last_gnt_d;
            lock_cnt_q     <= lock_cnt_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
            lock_timeout_q <= lock_timeout_d;
        end
    end

    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_rdata_o    = rsp_rdata_q;
    assign lock_timeout_o = lock_timeout_q;

endmodule

// File: tb/tb_mmio_periph_arbiter.sv
// Testbench for mmio_periph_arbiter: directed scenarios followed by a
// randomized run, checked against a transaction-level reference model.
module tb_mmio_periph_arbiter;

    localparam int unsigned N_REQ    = 2;
    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned LOCK_MAX = 16;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic [N_REQ-1:0]        req_valid_i;
    logic [N_REQ-1:0]        req_ready_o;
    logic [N_REQ*ADDR_W-1:0] req_addr_i;
    logic [N_REQ-1:0]        req_we_i;
    logic [N_REQ*DATA_W-1:0] req_wdata_i;
    logic [N_REQ-1:0]        req_lock_i;
    logic [N_REQ-1:0]        rsp_valid_o;
    logic [DATA_W-1:0]       rsp_rdata_o;
    logic [ADDR_W-1:0]       per_addr_o;
    logic                    per_write_en_o;
    logic [DATA_W-1:0]       per_data_o;
    logic [DATA_W-1:0]       per_data_i;
    logic                    lock_timeout_o;

    always #5 clk = ~clk;

    mmio_periph_arbiter #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_we_i(req_we_i),
        .req_wdata_i(req_wdata_i), .req_lock_i(req_lock_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .per_addr_o(per_addr_o), .per_write_en_o(per_write_en_o),
        .per_data_o(per_data_o), .per_data_i(per_data_i),
        .lock_timeout_o(lock_timeout_o)
    );

    // Binary to 8-digit packed BCD.
    function automatic logic [31:0] to_bcd(input logic [31:0] v);
        logic [31:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Peripheral stand-in: 0x04 reads the BCD of register 0x00.
    logic [31:0] per_mem [0:255];
    assign per_data_i = (per_addr_o == 8'h04) ? to_bcd(per_mem[0]) : per_mem[per_addr_o];
    always @(posedge clk) begin
        if (per_write_en_o) per_mem[per_addr_o] <= per_data_o;
    end

    // Reference model state.
    logic [31:0] ref_mem [0:255];
    bit          ref_locked;
    int          ref_owner;
    int          ref_last;
    int          ref_cnt;
    logic [1:0]  exp_rsp;
    logic [31:0] exp_rdata;
    logic        exp_to;

    int tests = 0;
    int fails = 0;

    function automatic logic [31:0] ref_read(input logic [7:0] a);
        return (a == 8'h04) ? to_bcd(ref_mem[0]) : ref_mem[a];
    endfunction

    task automatic model_reset();
        ref_locked = 0;
        ref_owner  = 0;
        ref_last   = 1;
        ref_cnt    = 0;
        exp_rsp    = '0;
        exp_rdata  = '0;
        exp_to     = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input bit vld, input logic [7:0] addr, input bit wr,
                           input logic [31:0] data, input bit lk);
        req_valid_i[i] = vld;
        req_addr_i[i*ADDR_W +: ADDR_W] = addr;
        req_we_i[i] = wr;
        req_wdata_i[i*DATA_W +: DATA_W] = data;
        req_lock_i[i] = lk;
    endtask

    // One cycle: check combinational grant, advance the model across the
    // edge, then check registered outputs. Called right after a negedge.
    task automatic step(input string tag, output logic [1:0] rdy);
        bit          wv;
        int          w;
        logic [7:0]  wa;
        logic [31:0] wd;
        bit          wwe, wlk;
        #1;
        wv = 0;
        w  = 0;
        if (ref_locked) begin
            if (req_valid_i[ref_owner]) begin wv = 1; w = ref_owner; end
        end else if (req_valid_i == 2'b11) begin
            wv = 1; w = 1 - ref_last;
        end else if (req_valid_i[0]) begin
            wv = 1; w = 0;
        end else if (req_valid_i[1]) begin
            wv = 1; w = 1;
        end
        wa  = req_addr_i[w*ADDR_W +: ADDR_W];
        wd  = req_wdata_i[w*DATA_W +: DATA_W];
        wwe = req_we_i[w];
        wlk = req_lock_i[w];
        rdy = req_ready_o;
        chk({tag, ".ready"}, 64'(req_ready_o), wv ? 64'(2'b01 << w) : 64'd0);
        chk({tag, ".per_addr"}, 64'(per_addr_o), wv ? 64'(wa) : 64'd0);
        chk({tag, ".per_we"}, 64'(per_write_en_o), wv ? 64'(wwe) : 64'd0);
        chk({tag, ".per_data"}, 64'(per_data_o), wv ? 64'(wd) : 64'd0);
        @(posedge clk);
        exp_rsp = '0;
        exp_to  = 1'b0;
        if (wv) begin
            exp_rsp[w] = 1'b1;
            ref_last   = w;
            if (wwe) ref_mem[wa] = wd;
            else     exp_rdata = ref_read(wa);
        end
        if (!ref_locked) begin
            if (wv && wlk) begin ref_locked = 1; ref_owner = w; ref_cnt = 0; end
        end else if (wv && !wlk) begin
            ref_locked = 0;
        end else if (ref_cnt == LOCK_MAX - 1) begin
            ref_locked = 0;
            exp_to     = 1'b1;
        end else begin
            ref_cnt++;
        end
        @(negedge clk);
        chk({tag, ".rsp_valid"}, 64'(rsp_valid_o), 64'(exp_rsp));
        chk({tag, ".rsp_rdata"}, 64'(rsp_rdata_o), 64'(exp_rdata));
        chk({tag, ".timeout"}, 64'(lock_timeout_o), 64'(exp_to));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] rdy;
        logic [1:0] rr_exp [4];
        logic [7:0] addrs [5];
        rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
        addrs  = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h18};
        for (int i = 0; i < 256; i++) begin
            per_mem[i] = '0;
            ref_mem[i] = '0;
        end
        req_valid_i = '0; req_addr_i = '0; req_we_i = '0;
        req_wdata_i = '0; req_lock_i = '0;
        model_reset();

        // Reset values
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset.rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("reset.rsp_rdata", 64'(rsp_rdata_o), 64'd0);
        chk("reset.timeout", 64'(lock_timeout_o), 64'd0);
        chk("reset.ready", 64'(req_ready_o), 64'd0);
        reset_n = 1'b1;

        // Single read
        set_req(0, 1, 8'h00, 0, 32'd0, 0);
        step("single", rdy);
        chk("single.rdy", 64'(rdy), 64'h1);
        chk("single.rsp", 64'(rsp_valid_o), 64'h1);
        chk("single.data", 64'(rsp_rdata_o), 64'h0);
        set_req(0, 0, 8'h00, 0, 32'd0, 0);

        // Write then dependent read
        set_req(1, 1, 8'h00, 1, 32'd1234, 0);
        step("wr", rdy);
        chk("wr.rsp", 64'(rsp_valid_o), 64'h2);
        set_req(1, 1, 8'h04, 0, 32'd0, 0);
        step("rd04", rdy);
        chk("rd04.rsp", 64'(rsp_valid_o), 64'h2);
        chk("rd04.data", 64'(rsp_rdata_o), 64'h1234);
        set_req(1, 0, 8'h00, 0, 32'd0, 0);

        // Round-robin under contention
        set_req(0, 1, 8'h08, 0, 32'd0, 0);
        set_req(1, 1, 8'h0C, 0, 32'd0, 0);
        for (int k = 0; k < 4; k++) begin
            step("rr", rdy);
            chk("rr.grant", 64'(rdy), 64'(rr_exp[k]));
            chk("rr.rsp", 64'(rsp_valid_o), 64'(rr_exp[k]));
        end

        // Lock hold and release
        set_req(0, 1, 8'h10, 1, 32'hA5A5_0001, 1);
        set_req(1, 1, 8'h00, 0, 32'd0, 0);
        step("lock.acq", rdy);
        chk("lock.acq.rdy", 64'(rdy), 64'h1);
        set_req(0, 0, 8'h00, 0, 32'd0, 0);
        for (int k = 0; k < 2; k++) begin
            step("lock.hold", rdy);
            chk("lock.hold.rdy", 64'(rdy), 64'h0);
        end
        set_req(0, 1, 8'h18, 1, 32'd1, 0);
        step("lock.rel", rdy);
        chk("lock.rel.rdy", 64'(rdy), 64'h1);
        chk("lock.rel.to", 64'(lock_timeout_o), 64'h0);
        set_req(0, 0, 8'h00, 0, 32'd0, 0);
        step("lock.after", rdy);
        chk("lock.after.rdy", 64'(rdy), 64'h2);
        set_req(1, 0, 8'h00, 0, 32'd0, 0);

        // Forced release
        set_req(0, 1, 8'h00, 0, 32'd0, 1);
        step("force.acq", rdy);
        chk("force.acq.rdy", 64'(rdy), 64'h1);
        set_req(0, 0, 8'h00, 0, 32'd0, 0);
        set_req(1, 1, 8'h08, 0, 32'd0, 0);
        for (int k = 1; k <= 16; k++) begin
            step("force.wait", rdy);
            chk("force.wait.rdy", 64'(rdy), 64'h0);
            chk("force.wait.to", 64'(lock_timeout_o), (k == 16) ? 64'h1 : 64'h0);
        end
        step("force.next", rdy);
        chk("force.next.rdy", 64'(rdy), 64'h2);
        set_req(1, 0, 8'h00, 0, 32'd0, 0);

        // Reset mid-lock with a response pending
        set_req(1, 1, 8'h04, 0, 32'd0, 1);
        step("rst.acq", rdy);
        chk("rst.acq.rdy", 64'(rdy), 64'h2);
        set_req(1, 1, 8'h00, 0, 32'd0, 1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        req_valid_i = '0;
        #1;
        chk("rst.rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("rst.rsp_rdata", 64'(rsp_rdata_o), 64'd0);
        chk("rst.timeout", 64'(lock_timeout_o), 64'd0);
        chk("rst.ready", 64'(req_ready_o), 64'd0);
        chk("rst.per_we", 64'(per_write_en_o), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        set_req(0, 1, 8'h08, 0, 32'd0, 0);
        set_req(1, 1, 8'h0C, 0, 32'd0, 0);
        step("rst.tie", rdy);
        chk("rst.tie.rdy", 64'(rdy), 64'h1);

        // Randomized traffic; a stalled request keeps its payload.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!(req_valid_i[i] && !rdy[i])) begin
                    if ($urandom_range(0, 2) != 0)
                        set_req(i, 1, addrs[$urandom_range(0, 4)], 1'($urandom_range(0, 1)),
                                $urandom, $urandom_range(0, 3) == 0);
                    else
                        set_req(i, 0, 8'h00, 0, 32'd0, 0);
                end
            end
            step("rnd", rdy);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
